// File: rtl/csu_seg_decoder_ctrl.sv
// csu_seg_decoder_ctrl: power sequencing and segmented code decode for the
// current-source-unit array. An 11-bit code is split into a thermometer part
// (optionally rotated by data-weighted averaging) and a binary part, with pdb
// sequencing that keeps currents off for a cycle before the array powers down.
module csu_seg_decoder_ctrl #(
    parameter int N_THERM    = 17,
    parameter int N_BIN      = 6,
    parameter int CODE_W     = 11,
    parameter int SETTLE_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              dem_en,
    input  logic              trim_red,
    input  logic [1:0]        atb_sel,
    output logic              pdb,
    output logic [1:0]        atb_ena,
    output logic [N_THERM-1:0] therm_en,
    output logic [N_BIN-1:0]  bin_en,
    output logic              bin0_red_en,
    output logic              ready,
    output logic              code_ack,
    output logic              sat
);

    localparam int M_W = CODE_W - N_BIN;
    localparam int P_W = (N_THERM > 1) ? $clog2(N_THERM) : 1;
    localparam int C_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CODE_W-1:0] FULL = CODE_W'(N_THERM * (2 ** N_BIN) + (2 ** N_BIN) - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [C_W-1:0]       r_cnt;
    logic [P_W-1:0]       r_ptr;
    logic [N_THERM-1:0]   r_therm;
    logic [N_BIN-1:0]     r_bin;
    logic                 r_red;
    logic                 r_sat;
    logic                 r_ack;
    logic [1:0]           r_atb;

    logic                 w_accept;
    logic                 w_settle_done;
    logic                 w_sat;
    logic [CODE_W-1:0]    w_code_cl;
    logic [M_W-1:0]       w_m;
    logic [N_BIN-1:0]     w_bin;
    logic [N_THERM-1:0]   w_lin;
    logic [2*N_THERM-1:0] w_rot_dbl;
    logic [N_THERM-1:0]   w_rot;
    logic [N_THERM-1:0]   w_therm_next;
    logic [P_W:0]         w_ptr_sum;
    logic [P_W:0]         w_ptr_wrap;

    assign w_accept      = code_valid && enable && (r_state == ST_ACTIVE);
    assign w_settle_done = (r_cnt == C_W'(SETTLE_CYC - 1));

    // Clamp the incoming code and split it into unary count and binary remainder
    assign w_sat     = (code > FULL);
    assign w_code_cl = w_sat ? FULL : code;
    assign w_m       = w_code_cl[CODE_W-1:N_BIN];
    assign w_bin     = w_code_cl[N_BIN-1:0];

    // Linear thermometer: the lowest m units on
    always_comb begin
        w_lin = '0;
        for (int i = 0; i < N_THERM; i++) begin
            w_lin[i] = (i < int'(w_m));
        end
    end

    // Rotate the linear pattern so it starts at the DWA pointer; bits shifted
    // past the top wrap back to unit 0.
    assign w_rot_dbl    = {{N_THERM{1'b0}}, w_lin} << r_ptr;
    assign w_rot        = w_rot_dbl[N_THERM-1:0] | w_rot_dbl[2*N_THERM-1:N_THERM];
    assign w_therm_next = dem_en ? w_rot : w_lin;

    // Next pointer is (p + m) mod N_THERM; p < N_THERM and m <= N_THERM so one subtract suffices
    assign w_ptr_sum  = (P_W+1)'(r_ptr) + (P_W+1)'(w_m);
    assign w_ptr_wrap = (w_ptr_sum >= (P_W+1)'(N_THERM)) ? (w_ptr_sum - (P_W+1)'(N_THERM)) : w_ptr_sum;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: power-up settles, power-down passes through a one-cycle drain
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OFF: begin
                if (enable) w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!enable)            w_state_next = ST_OFF;
                else if (w_settle_done) w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!enable) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_next = ST_OFF;
            end
            default: w_state_next = ST_OFF;
        endcase
    end

    // Outputs decoded from state: analog bias on in every state except OFF
    always_comb begin
        pdb   = 1'b0;
        ready = 1'b0;
        case (r_state)
            ST_OFF:    pdb = 1'b0;
            ST_SETTLE: pdb = 1'b1;
            ST_ACTIVE: begin
                pdb   = 1'b1;
                ready = 1'b1;
            end
            ST_DRAIN:  pdb = 1'b1;
            default:   pdb = 1'b0;
        endcase
    end

    // Settling counter runs only while in SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_cnt <= r_cnt + C_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Unit enables: load on accept, cleared on any exit from ACTIVE so currents stop before pdb falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_therm <= '0;
            r_bin   <= '0;
            r_red   <= 1'b0;
        end else if (w_accept) begin
            r_therm <= w_therm_next;
            r_bin   <= w_bin;
            r_red   <= trim_red;
        end else if (w_state_next != ST_ACTIVE) begin
            r_therm <= '0;
            r_bin   <= '0;
            r_red   <= 1'b0;
        end
    end

    // Saturation flag and DWA pointer persist through a session and clear on the way back to OFF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
            r_ptr <= '0;
        end else if (w_accept) begin
            r_sat <= w_sat;
            if (dem_en) r_ptr <= P_W'(w_ptr_wrap);
        end else if (r_state == ST_DRAIN) begin
            r_sat <= 1'b0;
            r_ptr <= '0;
        end
    end

    // Acknowledge pulse and registered testbus enable, the latter live only while staying in ACTIVE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_atb <= 2'b00;
        end else begin
            r_ack <= w_accept;
            r_atb <= ((r_state == ST_ACTIVE) && (w_state_next == ST_ACTIVE)) ? atb_sel : 2'b00;
        end
    end

    assign therm_en    = r_therm;
    assign bin_en      = r_bin;
    assign bin0_red_en = r_red;
    assign sat         = r_sat;
    assign code_ack    = r_ack;
    assign atb_ena     = r_atb;

endmodule

// File: tb/tb_csu_seg_decoder_ctrl.sv
// Bench for csu_seg_decoder_ctrl: directed power sequencing plus randomized
// codes checked through an expected-response queue against a reference model.
module tb_csu_seg_decoder_ctrl;

    localparam int N = 17;

    logic        clk = 1'b0;
    logic        rst_n, enable, code_valid, dem_en, trim_red;
    logic [10:0] code;
    logic [1:0]  atb_sel;
    logic        pdb, bin0_red_en, ready, code_ack, sat;
    logic [1:0]  atb_ena;
    logic [16:0] therm_en;
    logic [5:0]  bin_en;

    int n_chk  = 0;
    int n_fail = 0;
    int ptr_m  = 0;
    logic [24:0] exp_q[$];
    logic [24:0] last_exp = '0;

    always #5 clk = ~clk;

    csu_seg_decoder_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .code_valid(code_valid),
        .code(code), .dem_en(dem_en), .trim_red(trim_red), .atb_sel(atb_sel),
        .pdb(pdb), .atb_ena(atb_ena), .therm_en(therm_en), .bin_en(bin_en),
        .bin0_red_en(bin0_red_en), .ready(ready), .code_ack(code_ack), .sat(sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: clamp, split into unit count and remainder, place units from the rotation pointer
    task automatic model(input int cin, input bit dem, input bit trim, output logic [24:0] e);
        int c, m;
        bit s;
        logic [16:0] mask;
        s    = (cin > 1151);
        c    = s ? 1151 : cin;
        m    = c / 64;
        mask = '0;
        for (int k = 0; k < m; k++) begin
            if (dem) mask[(ptr_m + k) % N] = 1'b1;
            else     mask[k] = 1'b1;
        end
        if (dem) ptr_m = (ptr_m + m) % N;
        e = {s, trim, 6'(c % 64), mask};
    endtask

    task automatic send(input int c, input bit dem, input bit trim);
        logic [24:0] e;
        model(c, dem, trim, e);
        exp_q.push_back(e);
        last_exp   = e;
        code       = 11'(c);
        dem_en     = dem;
        trim_red   = trim;
        code_valid = 1'b1;
        cyc();
        code_valid = 1'b0;
        @(negedge clk);
        #1;
        check("ack_pending", exp_q.size(), 0);
    endtask

    task automatic power_up();
        enable     = 1'b1;
        code_valid = 1'b1;
        code       = 11'($urandom_range(0, 2047));
        cyc();
        check("pdb_rise", pdb, 1);
        check("ready_at_pdb_rise", ready, 0);
        for (int i = 1; i <= 64; i++) begin
            atb_sel = 2'($urandom_range(0, 3));
            cyc();
            check("ready_timing", ready, (i == 64));
            check("settle_enables_off", {atb_ena, therm_en, bin_en, bin0_red_en}, 0);
        end
        code_valid = 1'b0;
    endtask

    // Monitor: every acknowledge must match the oldest outstanding expectation
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk);
            if (code_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", code_ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_outputs", {sat, bin0_red_en, bin_en, therm_en}, e);
                end
            end
        end
    end

    initial begin
        logic [1:0] sel;
        rst_n = 1'b0; enable = 1'b0; code_valid = 1'b0; code = '0;
        dem_en = 1'b0; trim_red = 1'b0; atb_sel = 2'b00;
        #2;
        check("reset_outputs", {pdb, atb_ena, therm_en, bin_en, bin0_red_en, ready, code_ack, sat}, 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("off_pdb", pdb, 0);

        power_up();

        // Directed decode and saturation
        send(677, 0, 0);
        check("therm_677", therm_en, 17'h003FF);
        check("bin_677", bin_en, 6'h25);
        check("sat_677", sat, 0);
        send(2047, 0, 0);
        check("therm_sat", therm_en, 17'h1FFFF);
        check("bin_sat", bin_en, 6'h3F);
        check("sat_flag", sat, 1);
        send(64, 0, 1);
        check("therm_64", therm_en, 17'h00001);
        check("sat_clear", sat, 0);

        // DWA rotation sequence
        send(320, 1, 0);
        check("dwa_0_4", therm_en, 17'h0001F);
        send(320, 1, 1);
        check("dwa_5_9", therm_en, 17'h003E0);
        send(640, 1, 0);
        check("dwa_wrap", therm_en, 17'h1FC07);
        send(64, 1, 0);
        check("dwa_ptr3", therm_en, 17'h00008);

        // Randomized codes, idle gaps, testbus tracking
        for (int it = 0; it < 150; it++) begin
            sel     = 2'($urandom_range(0, 3));
            atb_sel = sel;
            if ($urandom_range(0, 3) != 0) begin
                send($urandom_range(0, 1) ? $urandom_range(0, 1151) : $urandom_range(0, 2047),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                cyc();
                check("hold_outputs", {sat, bin0_red_en, bin_en, therm_en}, last_exp);
                check("idle_no_ack", code_ack, 0);
            end
            check("atb_follow", atb_ena, sel);
            check("ready_hold", ready, 1);
        end

        // Power-down ordering with a code on the same cycle as the enable drop
        atb_sel = 2'b11;
        send(2047, 0, 1);
        cyc();
        check("atb_active", atb_ena, 2'b11);
        enable     = 1'b0;
        code_valid = 1'b1;
        code       = 11'd5;
        cyc();
        code_valid = 1'b0;
        check("drain_enables", {atb_ena, therm_en, bin_en, bin0_red_en}, 0);
        check("drain_pdb", pdb, 1);
        check("drain_ready", ready, 0);
        check("drain_sat_held", sat, 1);
        cyc();
        check("off_pdb_fall", pdb, 0);
        check("off_sat_clear", sat, 0);
        ptr_m = 0;

        // Asynchronous reset in the middle of SETTLE
        enable = 1'b1;
        repeat (20) cyc();
        check("settle_pdb", pdb, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_settle", {pdb, atb_ena, therm_en, bin_en, bin0_red_en, ready, code_ack, sat}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        power_up();
        send(320, 1, 0);
        check("dwa_after_settle_rst", therm_en, 17'h0001F);
        atb_sel = 2'b10;
        send(2047, 0, 1);
        cyc();

        // Asynchronous reset in the middle of ACTIVE, pointer must restart
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_active", {pdb, atb_ena, therm_en, bin_en, bin0_red_en, ready, code_ack, sat}, 0);
        ptr_m = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        power_up();
        send(320, 1, 0);
        check("dwa_ptr_restart", therm_en, 17'h0001F);

        repeat (2) cyc();
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
